// File: rtl/fp_to_int_pipe.sv
// Converts IEEE-754 binary32 to int32 with RNE rounding or truncation, saturating on overflow/NaN/inf.
// Latency 2 cycles (S1 decode/shift, S2 round/negate/saturate), one result per cycle.
// Backpressure: stalls on out_ready low, and in_ready drops only when both stages are full.
module fp_to_int_pipe #(
  parameter int TRUNC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  logic        s1_valid;
  logic        s1_load;
  logic        s2_load;

  logic        s1_sign;
  logic        s1_sat;
  logic        s1_nan;
  logic        s1_min;
  logic        s1_guard;
  logic        s1_sticky;
  logic [31:0] s1_mag;

  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic [23:0] man;
  logic [47:0] ext;
  logic        d_sat;
  logic        d_nan;
  logic        d_min;
  logic        d_guard;
  logic        d_sticky;
  logic [31:0] d_mag;

  logic        round_up;
  logic [31:0] rnd_mag;
  logic [31:0] res;

  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;

  // Right shifts cover e = 126..149; e = 126 naturally yields magnitude 0 with guard = 1.
  always_comb begin
    exp_f    = x[30:23];
    frac_f   = x[22:0];
    man      = {1'b1, frac_f};
    ext      = {man, 24'd0} >> (8'd150 - exp_f);
    d_sat    = 1'b0;
    d_nan    = 1'b0;
    d_min    = 1'b0;
    d_guard  = 1'b0;
    d_sticky = 1'b0;
    d_mag    = '0;
    if (exp_f == 8'd255 && frac_f != 23'd0) begin
      d_nan = 1'b1;
      d_sat = 1'b1;
    end else if (exp_f >= 8'd158) begin
      if (x == 32'hCF00_0000) d_min = 1'b1;
      else                    d_sat = 1'b1;
    end else if (exp_f >= 8'd150) begin
      d_mag = {8'd0, man} << (exp_f - 8'd150);
    end else if (exp_f >= 8'd126) begin
      d_mag    = {8'd0, ext[47:24]};
      d_guard  = ext[23];
      d_sticky = |ext[22:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (s1_load) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_sign   <= x[31];
      s1_sat    <= d_sat;
      s1_nan    <= d_nan;
      s1_min    <= d_min;
      s1_guard  <= d_guard;
      s1_sticky <= d_sticky;
      s1_mag    <= d_mag;
    end
  end

  // Magnitude is below 2^31 for e <= 157, so the increment cannot overflow.
  always_comb begin
    round_up = (TRUNC == 0) && s1_guard && (s1_sticky || s1_mag[0]);
    rnd_mag  = s1_mag + {31'd0, round_up};
    if (s1_sat)      res = (s1_nan || !s1_sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else if (s1_min) res = 32'h8000_0000;
    else             res = s1_sign ? -rnd_mag : rnd_mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y   <= res;
        ovf <= s1_sat;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Bench for fp_to_int_pipe: both rounding modes side by side, directed cases then random traffic
// scored against a real-arithmetic reference model.
module tb_fp_to_int_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] x;
  logic        out_ready;
  logic        in_ready0, out_valid0, ovf0;
  logic        in_ready1, out_valid1, ovf1;
  logic [31:0] y0, y1;

  fp_to_int_pipe #(.TRUNC(0)) u_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x(x),
    .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .ovf(ovf0)
  );

  fp_to_int_pipe #(.TRUNC(1)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .x(x),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        hold_vld = 1'b0;
  logic [32:0] hold0, hold1;
  logic        acc;
  logic        saw_low;
  int          idx;
  logic [31:0] rx;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact value as a real, rounded by the stated rule, then range-checked.
  function automatic logic [32:0] ref_conv(input logic [31:0] xv, input int trunc);
    int  e;
    real v, fl, fr, r, sv;
    e = int'(xv[30:23]);
    if (e == 255 && xv[22:0] != 23'd0) return {1'b1, 32'h7FFF_FFFF};
    if (e == 255) return xv[31] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    if (e == 0) return 33'd0;
    v = real'(int'({1'b1, xv[22:0]}));
    for (int p = 0; p < e - 150; p++) v = v * 2.0;
    for (int p = 0; p < 150 - e; p++) v = v / 2.0;
    fl = $floor(v);
    fr = v - fl;
    r  = fl;
    if (trunc == 0) begin
      if (fr > 0.5) r = fl + 1.0;
      else if (fr == 0.5 && $floor(fl / 2.0) * 2.0 != fl) r = fl + 1.0;
    end
    sv = xv[31] ? -r : r;
    if (sv > 2147483647.0 || sv < -2147483648.0)
      return xv[31] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    return {1'b0, 32'(longint'(sv))};
  endfunction

  // One cycle: drive at negedge, sample 1 time unit later, score the transfers due at the next posedge.
  task automatic step(input logic r, input logic iv, input logic [31:0] xv, input logic ordy,
                      output logic accepted);
    @(negedge clk);
    rst = r; in_valid = iv; x = xv; out_ready = ordy;
    #1;
    accepted = 1'b0;
    if (r) begin
      q0.delete();
      q1.delete();
      hold_vld = 1'b0;
    end else begin
      check("in_ready_rne", {32'd0, in_ready0}, {32'd0, (q0.size() < 2) || ordy});
      check("in_ready_trunc", {32'd0, in_ready1}, {32'd0, (q1.size() < 2) || ordy});
      if (hold_vld) begin
        check("hold_rne", {out_valid0, ovf0, y0}, {1'b1, hold0});
        check("hold_trunc", {out_valid1, ovf1, y1}, {1'b1, hold1});
      end
      if (out_valid0 && ordy) begin
        if (q0.size() == 0) check("spurious_rne", {32'd0, out_valid0}, 33'd0);
        else check("result_rne", {ovf0, y0}, q0.pop_front());
      end
      if (out_valid1 && ordy) begin
        if (q1.size() == 0) check("spurious_trunc", {32'd0, out_valid1}, 33'd0);
        else check("result_trunc", {ovf1, y1}, q1.pop_front());
      end
      hold_vld = out_valid0 && !ordy;
      hold0 = {ovf0, y0};
      hold1 = {ovf1, y1};
      if (iv && in_ready0) begin
        q0.push_back(ref_conv(xv, 0));
        q1.push_back(ref_conv(xv, 1));
        accepted = 1'b1;
      end
    end
  endtask

  logic [31:0] seq_x [4] = '{32'h4020_0000, 32'hC020_0000, 32'h3F00_0000, 32'h3F40_0000};
  logic [31:0] seq_y [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001};
  logic [31:0] sat_x [4] = '{32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000};
  logic [32:0] sat_y [4] = '{{1'b1, 32'h7FFF_FFFF}, {1'b0, 32'h8000_0000},
                             {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000}};
  logic [31:0] stl_x [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    step(1, 0, 0, 1, acc);
    step(1, 0, 0, 1, acc);

    // Reset state
    step(0, 0, 0, 1, acc);
    check("rst_out_valid", {32'd0, out_valid0}, 33'd0);
    check("rst_y_ovf", {ovf0, y0}, 33'd0);
    check("rst_in_ready", {32'd0, in_ready0}, 33'd1);

    // 1.5 in both modes, two-cycle latency
    step(0, 1, 32'h3FC0_0000, 1, acc);
    step(0, 0, 0, 1, acc);
    check("lat_early", {32'd0, out_valid0}, 33'd0);
    step(0, 0, 0, 1, acc);
    check("lat_valid", {32'd0, out_valid0}, 33'd1);
    check("one_half_rne", {ovf0, y0}, 33'h0_0000_0002);
    check("one_half_trunc", {ovf1, y1}, 33'h0_0000_0001);

    // Ties-to-even, back to back
    for (int k = 0; k < 6; k++) begin
      step(0, k < 4, (k < 4) ? seq_x[k] : 32'd0, 1, acc);
      if (k >= 2) begin
        check("b2b_valid", {32'd0, out_valid0}, 33'd1);
        check("b2b_y", {1'b0, y0}, {1'b0, seq_y[k-2]});
      end
    end

    // Saturation and the exact -2^31 boundary
    for (int k = 0; k < 4; k++) begin
      step(0, 1, sat_x[k], 1, acc);
      step(0, 0, 0, 1, acc);
      step(0, 0, 0, 1, acc);
      check("sat_rne", {ovf0, y0}, sat_y[k]);
      check("sat_trunc", {ovf1, y1}, sat_y[k]);
    end

    // Stall mid-stream for three cycles
    idx = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step(0, idx < 4, (idx < 4) ? stl_x[idx] : 32'd0, !(c >= 2 && c < 5), acc);
      if (!in_ready0) saw_low = 1'b1;
      if (acc) idx++;
    end
    check("stall_in_ready_dropped", {32'd0, saw_low}, 33'd1);
    check("stall_all_accepted", 33'(idx), 33'd4);
    check("stall_drained", 33'(q0.size()), 33'd0);

    // Reset with two operands in flight
    step(0, 1, 32'h4120_0000, 1, acc);
    step(0, 1, 32'h4130_0000, 1, acc);
    step(1, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);
    check("flush_out_valid", {32'd0, out_valid0}, 33'd0);
    check("flush_y", {ovf0, y0}, 33'd0);
    check("flush_in_ready", {32'd0, in_ready0}, 33'd1);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, acc);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rx = $urandom;
      if ($urandom_range(0, 1) == 1) rx[30:23] = 8'($urandom_range(120, 160));
      else if ($urandom_range(0, 15) == 0) rx[30:23] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      if ($urandom_range(0, 15) == 0) rx[22:0] = 23'd0;
      step(0, $urandom_range(0, 3) != 0, rx, $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 6; c++) step(0, 0, 0, 1, acc);
    check("final_drain_rne", 33'(q0.size()), 33'd0);
    check("final_drain_trunc", 33'(q1.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_to_int_pipe.md
FP_TO_INT_PIPE -- requirements
Module: fp_to_int_pipe

Interface
REQ-001 The block SHALL have parameter TRUNC, default 0, meaning 0 = round to nearest, ties to even, and 1 = truncate toward zero.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand is presented on x.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts x this cycle.
REQ-006 The block SHALL have port x, input, 32 bits: IEEE-754 binary32 operand.
REQ-007 The block SHALL have port out_valid, output, 1 bit: y and ovf hold a result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-009 The block SHALL have port y, output, 32 bits: signed two's-complement integer result.
REQ-010 The block SHALL have port ovf, output, 1 bit: the operand was NaN, infinity or outside the int32 range.

Function
REQ-011 Transfers SHALL occur on in_valid & in_ready at the input and on out_valid & out_ready at the output.
REQ-012 The block SHALL be a 2-stage pipeline: S1 = decode and shift, S2 = round, negate and saturate; S2 registers drive y, ovf and out_valid.
REQ-013 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; throughput SHALL be 1 result per cycle.
REQ-014 S2 SHALL load when ~out_valid | out_ready; S1 SHALL load when ~s1_valid | (S2 loads); in_ready SHALL equal the S1 load condition, with no combinational dependence on in_valid.
REQ-015 While out_valid & ~out_ready, y, ovf and out_valid SHALL be held stable; no result is dropped or duplicated.
REQ-016 Decode SHALL use e = x[30:23], m = {1, x[22:0]}; with e = 0 (zero or denormal) the magnitude SHALL be 0, ovf = 0.
REQ-017 With e < 126 the rounded magnitude SHALL be 0; with e = 126 it SHALL be 0 when TRUNC = 1 or when x is exactly ±0.5, else 1.
REQ-018 With 127 <= e <= 157 the magnitude SHALL be m shifted by (e - 150), right-shift retaining guard and sticky bits; RNE increments when guard & (sticky | lsb).
REQ-019 With e = 158 the magnitude is 2^31: result 0x80000000, ovf = 0 when x = 0xCF000000; otherwise saturate.
REQ-020 With e >= 159, infinity, or the other e = 158 cases, the block SHALL saturate: y = 0x7FFFFFFF for sign 0, or for any NaN (e = 255, fraction != 0); y = 0x80000000 for sign 1, non-NaN; ovf = 1.
REQ-021 Negative in-range results SHALL be the two's complement of the rounded magnitude; -0 SHALL yield 0.
REQ-022 Rounding SHALL never carry past bit 30 for e <= 157; no post-round saturation path is needed.

Reset
REQ-023 While rst = 1 at a clock edge, s1_valid and out_valid SHALL clear to 0, y to 0x00000000 and ovf to 0.
REQ-024 Reset mid-operation SHALL discard all in-flight operands; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-025 Data registers other than the outputs need not be reset; valid bits alone gate them.

Verification
REQ-026 x = 0x3FC00000 (1.5), out_ready = 1 -> y = 0x00000002, ovf = 0, two cycles after the transfer; with TRUNC = 1, y = 0x00000001.
REQ-027 The sequence 0x40200000 (2.5), 0xC0200000 (-2.5), 0x3F000000 (0.5), 0x3F400000 (0.75) back-to-back -> y = 2, 0xFFFFFFFE, 0, 1 on consecutive cycles.
REQ-028 x = 0x4F000000 -> y = 0x7FFFFFFF, ovf = 1; x = 0xCF000000 -> y = 0x80000000, ovf = 0; x = 0x7FC00000 -> y = 0x7FFFFFFF, ovf = 1; x = 0xFF800000 -> y = 0x80000000, ovf = 1.
REQ-029 Stream 4 operands with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, y is held stable, and all 4 results emerge in order with none lost.
REQ-030 Assert rst with 2 operands in flight -> out_valid = 0 next cycle, y = 0, and neither result ever appears.
REQ-031 Random binary32 against a reference model in both TRUNC settings, with random in_valid/out_ready -> bit-exact y and ovf.
